// File: rtl/fft_pkg.sv
// Shared definitions for the FFT magnitude reader: default sizes,
// FIFO word field offsets and the read-side FSM state encoding.
package fft_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_FRAME_LEN = 1024;

    // FIFO word layout: {re, im}, each DEF_DATA_W wide
    localparam int IM_LSB = 0;
    localparam int RE_LSB = DEF_DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

endpackage

// File: rtl/fft_mag_skid.sv
// Small synchronous FIFO holding finished output beats; head is
// presented combinationally. Ports: push/push_data, pop, head, count.
module fft_mag_skid
    import fft_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    function automatic logic [AW-1:0] bump(
        input logic [AW-1:0] p
    );
        return (p == LAST) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fft_mag_reader.sv
// Drains FFT bins from the result FIFO and streams |X|^2 with frame
// markers. Ports: FIFO read side (fifo_rd_en/fifo_rd_data/fifo_empty),
// output stream (mag_data/valid/ready/sof/eof, bin_idx), frame_cnt,
// busy. Define FFT_MAG_PEAK_EN to add peak_idx/peak_mag/peak_valid.
module fft_mag_reader
    import fft_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FRAME_LEN  = DEF_FRAME_LEN,
    parameter int SKID_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    output logic                         fifo_rd_en,
    input  logic [2*DATA_W-1:0]          fifo_rd_data,
    input  logic                         fifo_empty,
    output logic [2*DATA_W-1:0]          mag_data,
    output logic                         mag_valid,
    input  logic                         mag_ready,
    output logic                         mag_sof,
    output logic                         mag_eof,
    output logic [$clog2(FRAME_LEN)-1:0] bin_idx,
    output logic [15:0]                  frame_cnt,
    output logic                         busy
`ifdef FFT_MAG_PEAK_EN
   ,output logic [$clog2(FRAME_LEN)-1:0] peak_idx,
    output logic [2*DATA_W-1:0]          peak_mag,
    output logic                         peak_valid
`endif
);

    localparam int BW = $clog2(FRAME_LEN);
    localparam int MW = 2 * DATA_W;
    localparam int EW = MW + 2 + BW;
    localparam int CW = $clog2(SKID_DEPTH + 1);
    localparam logic [BW-1:0] LAST = BW'(FRAME_LEN - 1);

    state_t state, state_nx;

    logic [BW-1:0] rd_cnt;
    logic [BW-1:0] wr_bin;
    logic          v1, v2;
    logic          rd_go;
    logic          credit_ok;
    logic [CW:0]   need;
    logic [CW-1:0] occ;
    logic [EW-1:0] entry;
    logic [EW-1:0] head;
    logic          hs, eof_hs;

    logic signed [MW-1:0] re_x, im_x;
    logic [MW-1:0] sq_re, sq_im, sum;

    assign re_x = MW'($signed(fifo_rd_data[MW-1:DATA_W]));
    assign im_x = MW'($signed(fifo_rd_data[DATA_W-1:0]));

    // Reads still in the square/sum pipeline count against the buffer
    // so a stalled consumer can never overflow it.
    assign need = {1'b0, occ} + (CW+1)'(v1) + (CW+1)'(v2);
    assign credit_ok = need < (CW+1)'(SKID_DEPTH);

    always_comb begin
        state_nx = state;
        rd_go    = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable && !fifo_empty) state_nx = RUN;
            end
            RUN: begin
                rd_go = !fifo_empty && credit_ok;
                if (rd_go && rd_cnt == LAST) state_nx = DRAIN;
            end
            DRAIN: begin
                if (eof_hs) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign fifo_rd_en = rd_go;
    assign sum        = sq_re + sq_im;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rd_cnt    <= '0;
            wr_bin    <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            sq_re     <= '0;
            sq_im     <= '0;
            frame_cnt <= '0;
        end else begin
            state <= state_nx;
            v1    <= rd_go;
            v2    <= v1;
            if (rd_go) rd_cnt <= rd_cnt + BW'(1);
            if (v1) begin
                sq_re <= re_x * re_x;
                sq_im <= im_x * im_x;
            end
            if (v2) wr_bin <= wr_bin + BW'(1);
            if (eof_hs) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign entry = {sum, wr_bin == '0, wr_bin == LAST, wr_bin};

    fft_mag_skid #(
        .DEPTH (SKID_DEPTH),
        .W     (EW),
        .CW    (CW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (v2),
        .push_data (entry),
        .pop       (hs),
        .head      (head),
        .count     (occ)
    );

    assign mag_valid = occ != '0;
    assign mag_data  = head[EW-1 -: MW];
    assign mag_sof   = head[BW+1];
    assign mag_eof   = head[BW];
    assign bin_idx   = head[BW-1:0];
    assign hs        = mag_valid && mag_ready;
    assign eof_hs    = hs && mag_eof;
    assign busy      = (state != IDLE) || mag_valid;

`ifdef FFT_MAG_PEAK_EN
    logic [MW-1:0] pk_mag_r, c_mag;
    logic [BW-1:0] pk_idx_r, c_idx;

    // sof restarts the tracker; ties keep the earlier bin
    always_comb begin
        c_mag = pk_mag_r;
        c_idx = pk_idx_r;
        if (mag_sof || mag_data > pk_mag_r) begin
            c_mag = mag_data;
            c_idx = bin_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pk_mag_r   <= '0;
            pk_idx_r   <= '0;
            peak_mag   <= '0;
            peak_idx   <= '0;
            peak_valid <= 1'b0;
        end else begin
            peak_valid <= 1'b0;
            if (hs) begin
                pk_mag_r <= c_mag;
                pk_idx_r <= c_idx;
                if (mag_eof) begin
                    peak_mag   <= c_mag;
                    peak_idx   <= c_idx;
                    peak_valid <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_fft_mag_reader.sv
// Randomized bench for fft_mag_reader: FIFO model, expected-beat list
// and a per-cycle compare process.
module tb_fft_mag_reader;

    localparam int FL = 8;
    localparam int BW = $clog2(FL);

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          fifo_rd_en;
    logic [63:0]   fifo_rd_data = '0;
    logic          fifo_empty = 1'b1;
    logic [63:0]   mag_data;
    logic          mag_valid;
    logic          mag_ready = 1'b1;
    logic          mag_sof;
    logic          mag_eof;
    logic [BW-1:0] bin_idx;
    logic [15:0]   frame_cnt;
    logic          busy;
`ifdef FFT_MAG_PEAK_EN
    logic [BW-1:0] peak_idx;
    logic [63:0]   peak_mag;
    logic          peak_valid;
`endif

    fft_mag_reader #(
        .DATA_W     (32),
        .FRAME_LEN  (FL),
        .SKID_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .mag_data     (mag_data),
        .mag_valid    (mag_valid),
        .mag_ready    (mag_ready),
        .mag_sof      (mag_sof),
        .mag_eof      (mag_eof),
        .bin_idx      (bin_idx),
        .frame_cnt    (frame_cnt),
        .busy         (busy)
`ifdef FFT_MAG_PEAK_EN
       ,.peak_idx     (peak_idx),
        .peak_mag     (peak_mag),
        .peak_valid   (peak_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] mag;
        int          bin;
        bit          lit_en;
        logic [63:0] lit;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] stage[$];
    logic [63:0] fq[$];
    int          stage_rd = 0;
    int          nb = 0;
    int          ei = 0;
    int          checks = 0;
    int          failures = 0;
    bit          rnd_ready = 0;
    bit          rst_seen = 0;
    logic [15:0] fcnt = '0;
    exp_t        ce;

    bit          req = 0;
    string       req_name;
    logic [63:0] req_act, req_exp;

`ifdef FFT_MAG_PEAK_EN
    logic [63:0] m_pk = '0, pk_exp_mag = '0, last_pk_mag = '0;
    int          m_pk_idx = 0, pk_exp_idx = 0, last_pk_idx = -1;
    bit          pk_due = 0;
`endif

    function automatic logic [63:0] power(input int re, input int im);
        longint a, b;
        a = longint'(re) * longint'(re);
        b = longint'(im) * longint'(im);
        return $unsigned(a) + $unsigned(b);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input int re, input int im,
                             input bit lit_en, input logic [63:0] lit);
        exp_t e;
        stage.push_back({re, im});
        e.mag = power(re, im);
        e.bin = nb;
        e.lit_en = lit_en;
        e.lit = lit;
        exp_q.push_back(e);
        nb = (nb + 1) % FL;
    endtask

    task automatic req_check(input string nm, input logic [63:0] act,
                             input logic [63:0] ex);
        req_name = nm;
        req_act = act;
        req_exp = ex;
        req = 1;
        step(1);
        req = 0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n = 0;
        while ((ei < exp_q.size() || busy) && n < budget) begin
            step(1);
            n++;
        end
        req_check(nm, 64'(n < budget), 64'd1);
    endtask

    // Synchronous FIFO model: words pushed by the stimulus become
    // visible one edge later; read data appears the cycle after rd_en.
    always @(posedge clk) begin
        if (rst) begin
            fq.delete();
            stage_rd = stage.size();
        end else begin
            if (fifo_rd_en && fq.size() > 0)
                fifo_rd_data <= fq.pop_front();
            while (stage_rd < stage.size()) begin
                fq.push_back(stage[stage_rd]);
                stage_rd++;
            end
        end
        fifo_empty <= (fq.size() == 0);
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            mag_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    task automatic check64(input string nm, input logic [63:0] act,
                           input logic [63:0] ex);
        checks++;
        if (act !== ex) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, ex);
        end
    endtask

    always @(negedge clk) begin
        if (rst_seen) begin
            check64("rst_rd_en", fifo_rd_en, 0);
            check64("rst_valid", mag_valid, 0);
            check64("rst_data", mag_data, 0);
            check64("rst_sof", mag_sof, 0);
            check64("rst_eof", mag_eof, 0);
            check64("rst_bin", bin_idx, 0);
            check64("rst_frame_cnt", frame_cnt, 0);
            check64("rst_busy", busy, 0);
`ifdef FFT_MAG_PEAK_EN
            check64("rst_peak_valid", peak_valid, 0);
`endif
        end
        if (rst) begin
            ei = exp_q.size();
            fcnt = '0;
`ifdef FFT_MAG_PEAK_EN
            pk_due = 0;
`endif
        end else begin
            check64("rd_en_while_empty", fifo_rd_en & fifo_empty, 0);
            check64("frame_cnt", frame_cnt, fcnt);
`ifdef FFT_MAG_PEAK_EN
            check64("peak_valid", peak_valid, pk_due);
            if (pk_due) begin
                check64("peak_idx", peak_idx, pk_exp_idx);
                check64("peak_mag", peak_mag, pk_exp_mag);
                last_pk_idx = int'(peak_idx);
                last_pk_mag = peak_mag;
            end
            pk_due = 0;
`endif
            if (mag_valid) begin
                if (ei >= exp_q.size()) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_beat actual bin=%0d mag=%0h required none",
                             bin_idx, mag_data);
                end else begin
                    ce = exp_q[ei];
                    check64("mag", mag_data, ce.mag);
                    check64("bin_idx", bin_idx, ce.bin);
                    check64("sof", mag_sof, ce.bin == 0);
                    check64("eof", mag_eof, ce.bin == FL - 1);
                    if (ce.lit_en) begin
                        check64("lit_model", ce.mag, ce.lit);
                        check64("lit_dut", mag_data, ce.lit);
                    end
                    if (mag_ready) begin
`ifdef FFT_MAG_PEAK_EN
                        if (ce.bin == 0 || ce.mag > m_pk) begin
                            m_pk = ce.mag;
                            m_pk_idx = ce.bin;
                        end
                        if (ce.bin == FL - 1) begin
                            pk_due = 1;
                            pk_exp_mag = m_pk;
                            pk_exp_idx = m_pk_idx;
                        end
`endif
                        if (ce.bin == FL - 1) fcnt = fcnt + 16'd1;
                        ei++;
                    end
                end
            end
        end
        if (req) check64(req_name, req_act, req_exp);
        rst_seen = rst;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n;
        rst = 1;
        enable = 0;
        step(3);
        rst = 0;
        step(2);

        // constant bins
        enable = 1;
        for (int i = 0; i < FL; i++) push_word(3, 4, 1, 64'd25);
        wait_done(200, "t1_done");
        req_check("t1_frame_cnt", 64'(frame_cnt), 64'd1);

        // most negative components
        push_word(int'(32'h8000_0000), int'(32'h8000_0000), 1,
                  64'h8000_0000_0000_0000);
        for (int i = 1; i < FL; i++)
            push_word(int'($urandom), int'($urandom), 0, '0);
        wait_done(200, "t2_done");
        req_check("t2_frame_cnt", 64'(frame_cnt), 64'd2);

        // random backpressure and supply gaps over three frames
        rnd_ready = 1;
        for (int i = 0; i < 3 * FL; i++) begin
            push_word(int'($urandom), int'($urandom), 0, '0);
            if ($urandom_range(0, 3) == 0) step($urandom_range(1, 4));
        end
        wait_done(2000, "t3_done");
        rnd_ready = 0;
        req_check("t3_frame_cnt", 64'(frame_cnt), 64'd5);

        // FIFO runs dry mid-frame; enable dropped mid-frame
        for (int i = 0; i < 3; i++)
            push_word(int'($urandom_range(0, 999)), -7, 0, '0);
        step(4);
        enable = 0;
        step(20);
        for (int i = 0; i < 5; i++)
            push_word(int'($urandom_range(0, 999)), 11, 0, '0);
        wait_done(200, "t4_done");
        enable = 1;
        req_check("t4_frame_cnt", 64'(frame_cnt), 64'd6);

        // reset in the middle of a frame
        base = exp_q.size();
        for (int i = 0; i < FL; i++) push_word(i + 1, 0, 0, '0);
        n = 0;
        while (ei < base + 4 && n < 200) begin
            step(1);
            n++;
        end
        req_check("t5_reach4", 64'(n < 200), 64'd1);
        rst = 1;
        nb = 0;
        step(1);
        rst = 0;
        step(1);
        for (int i = 0; i < FL; i++) push_word(2, i, 0, '0);
        wait_done(200, "t5_done");
        req_check("t5_frame_cnt", 64'(frame_cnt), 64'd1);

`ifdef FFT_MAG_PEAK_EN
        push_word(1, 2, 1, 64'd5);
        push_word(3, 0, 1, 64'd9);
        push_word(1, 1, 1, 64'd2);
        push_word(0, 3, 1, 64'd9);
        push_word(1, 0, 1, 64'd1);
        push_word(0, 0, 1, 64'd0);
        push_word(2, 0, 1, 64'd4);
        push_word(0, 2, 1, 64'd4);
        wait_done(200, "t6_done");
        step(2);
        req_check("t6_peak_idx", 64'(last_pk_idx), 64'd1);
        req_check("t6_peak_mag", last_pk_mag, 64'd9);
`endif

        step(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
